// File: rtl/adc_fft_capture.sv
// rtl/adc_fft_capture.sv - ADC capture front end: offset-binary convert, decimate, trigger, frame write to FFT RAM
module adc_fft_capture #(
    parameter int ADC_WIDTH     = 12,
    parameter int ADDR_WIDTH    = 8,
    parameter int DECIM_WIDTH   = 8,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arm,
    input  logic [ADC_WIDTH-1:0]     ad_data,
    input  logic                     ad_valid,
    input  logic [DECIM_WIDTH-1:0]   decim,
    input  logic                     trig_en,
    input  logic [ADC_WIDTH-1:0]     trig_level,
    input  logic [ADC_WIDTH-1:0]     trig_hyst,
    input  logic [TIMEOUT_WIDTH-1:0] timeout,
    output logic [ADC_WIDTH-1:0]     fft_data_in,
    output logic [ADDR_WIDTH-1:0]    fft_addr_in,
    output logic                     fft_data_in_en,
    output logic                     busy,
    output logic                     capture_done,
    output logic                     triggered
);

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [DECIM_WIDTH-1:0]   decim_cnt;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     low_seen;
    logic [ADDR_WIDTH-1:0]    addr_cnt;
    logic                     active;
    logic                     strobe;
    logic [ADC_WIDTH-1:0]     low_thr;
    logic                     hit_trig;
    logic                     hit_tmo;
    logic                     arm_accept;
    logic                     start_frame;
    logic                     start_triggered;
    logic                     do_write;
    logic [ADC_WIDTH-1:0]     sample_signed;

    // Decimation and trigger only run while a capture is in flight.
    assign active   = (state == WAIT_TRIG) || (state == CAPTURE);
    assign strobe   = active && ad_valid && (decim_cnt == '0);
    // Hysteresis floor clamps at zero instead of wrapping to a huge code.
    assign low_thr  = (trig_level > trig_hyst) ? (trig_level - trig_hyst) : '0;
    assign hit_trig = low_seen && (ad_data >= trig_level);
    assign hit_tmo  = (timeout != '0) && (tmo_cnt >= timeout);
    // Offset-binary to two's complement is just an MSB flip.
    assign sample_signed = {~ad_data[ADC_WIDTH-1], ad_data[ADC_WIDTH-2:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-cycle control strobes for the datapath.
    always_comb begin
        state_nxt       = state;
        arm_accept      = 1'b0;
        start_frame     = 1'b0;
        start_triggered = 1'b0;
        do_write        = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    arm_accept = 1'b1;
                    state_nxt  = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (strobe && (!trig_en || hit_trig || hit_tmo)) begin
                    start_frame     = 1'b1;
                    start_triggered = trig_en && hit_trig;
                    do_write        = 1'b1;
                    state_nxt       = CAPTURE;
                end
            end
            CAPTURE: begin
                if (strobe) begin
                    do_write = 1'b1;
                    if (addr_cnt == '1) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: write port, counters, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fft_data_in    <= '0;
            fft_addr_in    <= '0;
            fft_data_in_en <= 1'b0;
            busy           <= 1'b0;
            capture_done   <= 1'b0;
            triggered      <= 1'b0;
            decim_cnt      <= '0;
            tmo_cnt        <= '0;
            low_seen       <= 1'b0;
            addr_cnt       <= '0;
        end else begin
            fft_data_in_en <= do_write;
            // DONE follows the last write enable by one cycle in the state
            // register, so registering it lands the pulse one cycle after it.
            capture_done   <= (state == DONE);

            if (do_write) begin
                fft_data_in <= sample_signed;
                fft_addr_in <= addr_cnt;
                addr_cnt    <= addr_cnt + 1'b1;
            end else if (arm_accept) begin
                addr_cnt <= '0;
            end

            if (arm_accept) begin
                busy <= 1'b1;
            end else if (state == DONE) begin
                busy <= 1'b0;
            end

            if (start_frame) begin
                triggered <= start_triggered;
            end

            if (arm_accept) begin
                decim_cnt <= '0;
            end else if (active && ad_valid) begin
                if (decim_cnt == '0) begin
                    decim_cnt <= (decim == '0) ? '0 : (decim - 1'b1);
                end else begin
                    decim_cnt <= decim_cnt - 1'b1;
                end
            end

            if (arm_accept) begin
                tmo_cnt <= '0;
            end else if ((state == WAIT_TRIG) && (tmo_cnt != '1)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (arm_accept) begin
                low_seen <= 1'b0;
            end else if ((state == WAIT_TRIG) && strobe && (ad_data < low_thr)) begin
                low_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_fft_capture.sv
// tb/tb_adc_fft_capture.sv - randomized self-checking bench for adc_fft_capture
module tb_adc_fft_capture;

    localparam int N     = 6000;
    localparam int FRAME = 256;

    logic        clk;
    logic        rst_n;
    logic        arm;
    logic [11:0] ad_data;
    logic        ad_valid;
    logic [7:0]  decim;
    logic        trig_en;
    logic [11:0] trig_level;
    logic [11:0] trig_hyst;
    logic [19:0] timeout;
    logic [11:0] fft_data_in;
    logic [7:0]  fft_addr_in;
    logic        fft_data_in_en;
    logic        busy;
    logic        capture_done;
    logic        triggered;

    int errors = 0;
    int checks = 0;

    logic [11:0] sd [N];
    bit          sv [N];
    bit          sa [N];
    int          exp_cyc [FRAME];
    logic [11:0] exp_dat [FRAME];
    int          obs_cyc [FRAME];
    int          obs_addr [FRAME];
    logic [11:0] obs_dat [FRAME];

    adc_fft_capture dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .arm            (arm),
        .ad_data        (ad_data),
        .ad_valid       (ad_valid),
        .decim          (decim),
        .trig_en        (trig_en),
        .trig_level     (trig_level),
        .trig_hyst      (trig_hyst),
        .timeout        (timeout),
        .fft_data_in    (fft_data_in),
        .fft_addr_in    (fft_addr_in),
        .fft_data_in_en (fft_data_in_en),
        .busy           (busy),
        .capture_done   (capture_done),
        .triggered      (triggered)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 ramp, 1 ramp gappy valid, 2 triangle, 3 triangle gappy,
    //       4 constant 0x900, 5 random data gappy valid
    task automatic build_stim(input int kind);
        int val;
        int dir;
        int step;
        val  = $urandom_range(12'h400, 12'hC00);
        dir  = $urandom_range(0, 1) ? 1 : -1;
        step = $urandom_range(8, 40);
        for (int c = 0; c < N; c++) begin
            sa[c] = 1'b0;
            sv[c] = (kind == 1 || kind == 3 || kind == 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (kind)
                0, 1: sd[c] = 12'((c == 0) ? 0 : c - 1);
                2, 3: begin
                    sd[c] = 12'(val);
                    val   = val + dir * step;
                    if (val >= 12'hC00) begin val = 12'hC00; dir = -1; end
                    if (val <= 12'h400) begin val = 12'h400; dir = 1; end
                end
                4:       sd[c] = 12'h900;
                default: sd[c] = 12'($urandom_range(0, 12'hFFF));
            endcase
        end
        sa[0] = 1'b1;
    endtask

    // Reference: walk the kept (decimated) samples after arm, find the first
    // one that qualifies as frame start, then the next 255 kept samples.
    task automatic model(input int decim_i, input bit ten, input int lvl, input int hy,
                         input int tmo, output int nk, output bit exp_trig);
        int  dd;
        int  lthr;
        int  vcount;
        bit  low;
        bit  started;
        dd       = (decim_i == 0) ? 1 : decim_i;
        lthr     = (lvl > hy) ? lvl - hy : 0;
        vcount   = 0;
        low      = 1'b0;
        started  = 1'b0;
        nk       = 0;
        exp_trig = 1'b0;
        for (int c = 1; c < N - 2; c++) begin
            if (sv[c]) begin
                if (vcount % dd == 0) begin
                    if (!started) begin
                        if (!ten) begin
                            started = 1'b1;
                        end else if (low && int'(sd[c]) >= lvl) begin
                            started  = 1'b1;
                            exp_trig = 1'b1;
                        end else if (tmo != 0 && (c - 1) >= tmo) begin
                            started = 1'b1;
                        end else if (int'(sd[c]) < lthr) begin
                            low = 1'b1;
                        end
                    end
                    if (started && nk < FRAME) begin
                        exp_cyc[nk] = c + 1;
                        exp_dat[nk] = sd[c] ^ 12'h800;
                        nk++;
                    end
                end
                vcount++;
            end
        end
    endtask

    task automatic run_frame(input int decim_i, input bit ten, input int lvl, input int hy,
                             input int tmo, input int kind, input bit arm_tests, input bit abort);
        int nk;
        bit exp_trig;
        int exp_done;
        int end_cyc;
        int nw;
        int done_cyc;
        int done_cnt;
        int nexp;
        build_stim(kind);
        model(decim_i, ten, lvl, hy, tmo, nk, exp_trig);
        exp_done = (nk == FRAME) ? exp_cyc[FRAME-1] + 1 : N - 2;
        end_cyc  = abort ? exp_cyc[50] : exp_done + 1;
        if (arm_tests) begin
            sa[exp_cyc[100]]     = 1'b1;
            sa[exp_cyc[FRAME-1]] = 1'b1;
            sa[exp_done]         = 1'b1;
        end
        decim      = 8'(decim_i);
        trig_en    = ten;
        trig_level = 12'(lvl);
        trig_hyst  = 12'(hy);
        timeout    = 20'(tmo);
        nw         = 0;
        done_cyc   = -1;
        done_cnt   = 0;
        for (int c = 0; c <= end_cyc; c++) begin
            @(negedge clk);
            if (fft_data_in_en) begin
                if (nw < FRAME) begin
                    obs_cyc[nw]  = c;
                    obs_addr[nw] = int'(fft_addr_in);
                    obs_dat[nw]  = fft_data_in;
                end
                nw++;
            end
            if (capture_done) begin
                if (done_cyc < 0) done_cyc = c;
                done_cnt++;
            end
            if (c == 1) check("busy_after_arm", busy, 1);
            if (!abort && c == exp_done) begin
                check("busy_at_done", busy, 0);
                check("triggered", triggered, exp_trig);
                check("addr_hold", fft_addr_in, 8'hFF);
                check("data_hold", fft_data_in, exp_dat[FRAME-1]);
            end
            if (!abort && c == exp_done + 1) begin
                check("busy_after_done", busy, arm_tests);
            end
            if (abort && c == end_cyc) begin
                rst_n = 1'b0;
                #1;
                check("abort_outputs", {fft_data_in_en, busy, capture_done, triggered,
                                        fft_addr_in, fft_data_in}, 0);
                break;
            end
            arm      = sa[c];
            ad_valid = sv[c];
            ad_data  = sd[c];
        end
        arm      = 1'b0;
        ad_valid = 1'b0;
        nexp     = abort ? 51 : FRAME;
        check("n_writes", nw, nexp);
        for (int i = 0; i < nexp && i < nw && i < FRAME; i++) begin
            check($sformatf("wr_cyc[%0d]", i), obs_cyc[i], exp_cyc[i]);
            check($sformatf("wr_addr[%0d]", i), obs_addr[i], i);
            check($sformatf("wr_data[%0d]", i), obs_dat[i], exp_dat[i]);
        end
        if (abort) begin
            repeat (3) begin
                @(negedge clk);
                if (capture_done) done_cnt++;
            end
            check("abort_no_done", done_cnt, 0);
            rst_n = 1'b1;
        end else begin
            check("done_cyc", done_cyc, exp_done);
            check("done_cnt", done_cnt, 1);
        end
        if (arm_tests) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        arm        = 1'b0;
        ad_data    = '0;
        ad_valid   = 1'b0;
        decim      = 8'd1;
        trig_en    = 1'b0;
        trig_level = '0;
        trig_hyst  = '0;
        timeout    = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {fft_data_in_en, busy, capture_done, triggered,
                                fft_addr_in, fft_data_in}, 0);
        rst_n = 1'b1;

        run_frame(1, 0, 0, 0, 0, 0, 0, 0);
        run_frame(4, 0, 0, 0, 0, 0, 0, 0);
        run_frame(1, 1, 12'h800, 12'h100, 0, 2, 0, 0);
        run_frame(2, 1, 12'h800, 12'h100, 0, 3, 0, 0);
        run_frame(1, 1, 12'h800, 12'h100, 1000, 4, 0, 0);
        run_frame(1, 0, 0, 0, 0, 0, 1, 0);
        run_frame(1, 0, 0, 0, 0, 1, 0, 1);
        run_frame(3, 0, 0, 0, 0, 5, 0, 0);
        run_frame(0, 1, $urandom_range(12'h100, 12'hF00), $urandom_range(0, 12'h300), 500, 5, 0, 0);
        run_frame(2, 1, 12'h050, 12'h100, 300, 5, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
